// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   kind_e   : request kind carried on req_kind
//   state_e  : sequencing states of the encoder
//   OP_*     : 7-bit major opcodes placed in insn[6:0]
//   XLEN_DEFAULT : default instruction / address width
package instr_encoder_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    KIND_LW   = 3'd0,
    KIND_SW   = 3'd1,
    KIND_R    = 3'd2,
    KIND_LUI  = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_IALU = 3'd5,
    KIND_JAL  = 3'd6,
    KIND_JALR = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRx = 3'b101;

endpackage

// File: rtl/instr_fifo.sv
// Output FIFO holding encoded instruction words until the instruction
// memory accepts them.
//   clk, reset      : clock, asynchronous active-low reset (pointers only)
//   push, push_data : write an entry (allowed when full if popping too)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry, stable until popped
//   empty, full     : occupancy flags
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] head,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder. Accepts encode requests, assembles the 32-bit
// instruction word combinationally, queues it in an output FIFO and writes
// it to instruction memory at consecutive word addresses.
//   clk, reset                 : clock, asynchronous active-low reset
//   start, base_addr           : begin a run at base_addr
//   finish                     : stop accepting and drain the FIFO
//   req_valid / req_ready      : request handshake
//   req_kind, req_funct3, req_funct7b5, req_rd, req_rs1, req_rs2, req_imm
//                              : request fields
//   imem_we, imem_addr, imem_wd, imem_ready : instruction-memory write port
//   busy, done, err, count     : status (done pulses, err is sticky,
//                                count = words written this run)
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XLEN-1:0]        base_addr,
  input  logic                   finish,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_kind,
  input  logic [2:0]             req_funct3,
  input  logic                   req_funct7b5,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs1,
  input  logic [4:0]             req_rs2,
  input  logic signed [XLEN-1:0] req_imm,
  output logic                   imem_we,
  output logic [XLEN-1:0]        imem_addr,
  output logic [XLEN-1:0]        imem_wd,
  input  logic                   imem_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [XLEN-1:0]        count
);

  state_e          state;
  kind_e           kind_p0;
  logic [31:0]     insn_p0;
  logic [2:0]      f3_p0;
  logic            shift_p0;
  logic            misalign_p0;
  logic            accept_p0;
  logic            vld_p0;
  logic [XLEN-1:0] word_p0;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;

  // ---- stage p0: combinational encode of the offered request ----
  assign kind_p0     = kind_e'(req_kind);
  assign shift_p0    = (kind_p0 == KIND_IALU) &&
                       ((req_funct3 == F3_SLL) || (req_funct3 == F3_SRx));
  assign f3_p0       = ((kind_p0 == KIND_BEQ) || (kind_p0 == KIND_JALR)) ? 3'b000 : req_funct3;
  // Branch and jump offsets must be even; such requests are consumed but dropped.
  assign misalign_p0 = ((kind_p0 == KIND_BEQ) || (kind_p0 == KIND_JAL)) && req_imm[0];

  always_comb begin
    insn_p0 = '0;
    case (kind_p0)
      KIND_LW:   insn_p0 = {req_imm[11:0], req_rs1, f3_p0, req_rd, OP_LW};
      KIND_JALR: insn_p0 = {req_imm[11:0], req_rs1, f3_p0, req_rd, OP_JALR};
      KIND_IALU: begin
        if (shift_p0)
          insn_p0 = {1'b0, req_funct7b5, 5'b00000, req_imm[4:0], req_rs1, f3_p0, req_rd, OP_IALU};
        else
          insn_p0 = {req_imm[11:0], req_rs1, f3_p0, req_rd, OP_IALU};
      end
      KIND_R:    insn_p0 = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1, f3_p0, req_rd, OP_R};
      KIND_SW:   insn_p0 = {req_imm[11:5], req_rs2, req_rs1, f3_p0, req_imm[4:0], OP_SW};
      KIND_BEQ:  insn_p0 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3_p0,
                            req_imm[4:1], req_imm[11], OP_BEQ};
      KIND_LUI:  insn_p0 = {req_imm[31:12], req_rd, OP_LUI};
      KIND_JAL:  insn_p0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OP_JAL};
      default:   insn_p0 = '0;
    endcase
  end

  assign word_p0   = XLEN'(insn_p0);
  // finish has priority over a request arriving in the same cycle.
  assign req_ready = (state == ST_RUN) && !fifo_full && !finish;
  assign accept_p0 = req_valid && req_ready;
  assign vld_p0    = accept_p0 && !misalign_p0;

  // ---- stage p1: queued words presented to instruction memory ----
  instr_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p0),
    .push_data (word_p0),
    .pop       (pop),
    .head      (imem_wd),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign imem_we = !fifo_empty;
  assign pop     = imem_we && imem_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      imem_addr <= '0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        imem_addr <= imem_addr + XLEN'(4);
        count     <= count + XLEN'(1);
      end
      if (accept_p0 && misalign_p0) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            count     <= '0;
            err       <= 1'b0;
            imem_addr <= base_addr;
          end
        end
        ST_RUN: begin
          if (finish) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Empty FIFO means no write is pending toward memory.
          if (fifo_empty) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic [31:0] base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_funct7b5 = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        imem_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .finish       (finish),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_funct3   (req_funct3),
    .req_funct7b5 (req_funct7b5),
    .req_rd       (req_rd),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_imm      (req_imm),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wd      (imem_wd),
    .imem_ready   (imem_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .count        (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extract imm[hi:lo] as a plain number.
  function automatic longint unsigned fld(input logic [31:0] v, input int hi, input int lo);
    longint unsigned x;
    x = {32'd0, v};
    return (x >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Reference encoding: each field is a number scaled to its bit position.
  function automatic logic [31:0] model_word(input int k, input int f3, input int f7,
                                             input int rd, input int rs1, input int rs2,
                                             input logic [31:0] imm);
    longint unsigned w, RD, RS1, RS2, F3, F7;
    RD = longint'(rd); RS1 = longint'(rs1); RS2 = longint'(rs2);
    F3 = longint'(f3); F7 = longint'(f7);
    case (k)
      0: w = 64'd3 + (fld(imm, 11, 0) << 20) + (RS1 << 15) + (F3 << 12) + (RD << 7);
      1: w = 64'd35 + (fld(imm, 11, 5) << 25) + (RS2 << 20) + (RS1 << 15) + (F3 << 12)
             + (fld(imm, 4, 0) << 7);
      2: w = 64'd51 + (F7 << 30) + (RS2 << 20) + (RS1 << 15) + (F3 << 12) + (RD << 7);
      3: w = 64'd55 + (fld(imm, 31, 12) << 12) + (RD << 7);
      4: w = 64'd99 + (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + (RS2 << 20)
             + (RS1 << 15) + (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7);
      5: begin
        if (f3 == 1 || f3 == 5)
          w = 64'd19 + (F7 << 30) + (fld(imm, 4, 0) << 20) + (RS1 << 15) + (F3 << 12) + (RD << 7);
        else
          w = 64'd19 + (fld(imm, 11, 0) << 20) + (RS1 << 15) + (F3 << 12) + (RD << 7);
      end
      6: w = 64'd111 + (fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21)
             + (fld(imm, 11, 11) << 20) + (fld(imm, 19, 12) << 12) + (RD << 7);
      default: w = 64'd103 + (fld(imm, 11, 0) << 20) + (RS1 << 15) + (RD << 7);
    endcase
    return w[31:0];
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] q[$];
  logic [31:0] log_wd[$];
  logic [31:0] log_addr[$];
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_count = '0;
  bit          exp_err = 1'b0;
  bit          exp_done = 1'b0;
  int          mstate = 0;   // 0 idle, 1 run, 2 drain

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      exp_addr = '0; exp_count = '0; exp_err = 1'b0; exp_done = 1'b0; mstate = 0;
      chk("rst_we",    32'(imem_we),   32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_err",   32'(err),       32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_count", count,          32'd0);
      chk("rst_addr",  imem_addr,      32'd0);
    end else begin : cmp
      int occ;
      bit rdy_m;
      occ   = q.size();
      rdy_m = (mstate == 1) && (occ < DEPTH) && !finish;
      chk("we", 32'(imem_we), 32'(occ != 0));
      if (occ != 0) begin
        chk("wd",   imem_wd,   q[0]);
        chk("addr", imem_addr, exp_addr);
      end
      chk("count", count,           exp_count);
      chk("err",   32'(err),        32'(exp_err));
      chk("done",  32'(done),       32'(exp_done));
      chk("busy",  32'(busy),       32'(mstate != 0));
      chk("ready", 32'(req_ready),  32'(rdy_m));

      if (imem_we && imem_ready) begin
        log_wd.push_back(imem_wd);
        log_addr.push_back(imem_addr);
      end
      exp_done = 1'b0;
      if (occ != 0 && imem_ready) begin
        void'(q.pop_front());
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 32'd1;
      end
      if (req_valid && rdy_m) begin
        if ((req_kind == 3'd4 || req_kind == 3'd6) && req_imm[0])
          exp_err = 1'b1;
        else
          q.push_back(model_word(int'(req_kind), int'(req_funct3), int'(req_funct7b5),
                                 int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm));
      end
      case (mstate)
        0: if (start) begin
          mstate = 1; exp_count = '0; exp_err = 1'b0; exp_addr = base_addr;
        end
        1: if (finish) mstate = 2;
        default: if (occ == 0) begin mstate = 0; exp_done = 1'b1; end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int k, input int f3, input int f7, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    req_kind = k[2:0]; req_funct3 = f3[2:0]; req_funct7b5 = f7[0];
    req_rd = rd[4:0]; req_rs1 = rs1[4:0]; req_rs2 = rs2[4:0]; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: kind %0d not accepted within 50 cycles", k);
    end
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_addr = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 200 && log_wd.size() < n; i++) @(posedge clk);
    #1;
    chk("log_size", 32'(log_wd.size()), 32'(n));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit got;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Basic encodings at base 0x100.
    pulse_start(32'h100);
    send(5, 0, 0, 1, 0, 0, 32'd5);             // addi x1,x0,5
    send(0, 2, 0, 2, 1, 7, 32'd8);             // lw x2,8(x1) (stray rs2 ignored)
    send(1, 2, 0, 0, 1, 2, 32'd4);             // sw x2,4(x1)
    send(4, 7, 0, 0, 1, 2, -32'sd4);           // beq x1,x2,-4 (funct3 forced 0)
    send(6, 0, 0, 1, 0, 0, 32'd8);             // jal x1,8
    send(3, 0, 0, 5, 3, 0, 32'h12345000);      // lui x5,0x12345
    wait_log(6);
    chk("w0_wd", log_wd[0], 32'h00500093); chk("w0_addr", log_addr[0], 32'h100);
    chk("w1_wd", log_wd[1], 32'h0080A103); chk("w1_addr", log_addr[1], 32'h104);
    chk("w2_wd", log_wd[2], 32'h0020A223); chk("w2_addr", log_addr[2], 32'h108);
    chk("w3_wd", log_wd[3], 32'hFE208EE3);
    chk("w4_wd", log_wd[4], 32'h008000EF);
    chk("w5_wd", log_wd[5], 32'h123452B7);

    // start during RUN must be ignored; more kinds.
    pulse_start(32'h9000);
    send(2, 0, 1, 3, 1, 2, 32'd0);             // sub x3,x1,x2
    send(5, 5, 1, 4, 1, 0, 32'hFFFFFFE3);      // srai x4,x1,3
    send(7, 7, 0, 1, 2, 0, -32'sd8);           // jalr x1,-8(x2) (funct3 forced 0)
    wait_log(9);
    chk("w6_wd", log_wd[6], 32'h402081B3); chk("w6_addr", log_addr[6], 32'h118);
    chk("w7_wd", log_wd[7], 32'h4030D213);
    chk("w8_wd", log_wd[8], 32'hFF8100E7); chk("w8_addr", log_addr[8], 32'h120);

    // Backpressure: memory stalls while 6 requests are offered.
    imem_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(5, 0, 0, i + 1, 0, 0, 32'(i));
          accepted++;
        end
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("bp_accepts",  32'(accepted),  32'd4);
        chk("bp_ready",    32'(req_ready), 32'd0);
        chk("bp_hold_wd",  imem_wd,        32'h00000093);
        chk("bp_hold_adr", imem_addr,      32'h124);
        imem_ready = 1'b1;
      end
    join
    wait_log(15);
    chk("w14_wd", log_wd[14], 32'h00500313); chk("w14_addr", log_addr[14], 32'h138);

    // Misaligned jal: consumed, nothing written, err set.
    send(6, 0, 0, 1, 0, 0, 32'd3);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_we",  32'(imem_we), 32'd0);

    // finish together with a request: finish wins.
    req_kind = 3'd5; req_funct3 = 3'd0; req_rd = 5'd9; req_rs1 = 5'd0; req_imm = 32'd1;
    req_valid = 1'b1; finish = 1'b1;
    @(negedge clk);
    chk("fin_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    finish = 1'b0; req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen",  32'(got),   32'd1);
    chk("done_count", count,      32'd15);
    chk("done_busy",  32'(busy),  32'd0);
    @(posedge clk); #1;
    chk("fin_nowrite", 32'(log_wd.size()), 32'd15);

    // Address wrap and err cleared by start.
    pulse_start(32'hFFFFFFFC);
    chk("start_err", 32'(err), 32'd0);
    send(5, 0, 0, 1, 0, 0, 32'd1);
    send(5, 0, 0, 2, 0, 0, 32'd2);
    wait_log(17);
    chk("wrap0_addr", log_addr[15], 32'hFFFFFFFC);
    chk("wrap1_addr", log_addr[16], 32'h00000000);

    // Reset in the middle of a drain with 3 words queued.
    imem_ready = 1'b0;
    send(5, 0, 0, 3, 0, 0, 32'd3);
    send(5, 0, 0, 4, 0, 0, 32'd4);
    send(5, 0, 0, 5, 0, 0, 32'd5);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(posedge clk); #1;
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_cnt",  count,     32'd2);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",    32'(imem_we), 32'd0);
    chk("mid_rst_count", count,        32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_addr",  imem_addr,    32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    imem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_we",  32'(imem_we), 32'd0);
    chk("post_rst_log", 32'(log_wd.size()), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, sets the output FIFO entry count (power of two, >=2).
REQ-002 Parameter XLEN, default 32, sets the instruction and address width.
REQ-003 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 start  input  1  One-cycle pulse: load base_addr and enter RUN.
REQ-006 base_addr  input  XLEN  First instruction-memory write address.
REQ-007 finish  input  1  One-cycle pulse: stop accepting requests and drain the FIFO.
REQ-008 req_valid / req_ready  input / output  1 / 1  Encode-request handshake.
REQ-009 req_kind  input  3  Kind: 0 lw, 1 sw, 2 R-type, 3 lui, 4 beq, 5 I-ALU, 6 jal, 7 jalr.
REQ-010 req_funct3, req_funct7b5  input  3, 1  funct3 field and funct7 bit 5.
REQ-011 req_rd, req_rs1, req_rs2  input  5 each  Register fields.
REQ-012 req_imm  input  XLEN  Sign-extended immediate (byte offset for beq/jal; upper value imm[31:12] for lui).
REQ-013 imem_we, imem_addr, imem_wd  output  1, XLEN, XLEN  Instruction-memory write port.
REQ-014 imem_ready  input  1  Memory accepts a write in any cycle where imem_we && imem_ready.
REQ-015 busy, done, err, count  output  1, 1, 1, XLEN  Status outputs; done is a pulse, err is sticky, count is the number of words written.

Function
REQ-016 States: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN on finish; DRAIN->IDLE when the FIFO is empty and no write is in flight.
REQ-017 req_ready = (state==RUN) && FIFO not full && !finish; a transfer completes when req_valid && req_ready.
REQ-018 Opcodes: lw 0000011, sw 0100011, R 0110011, lui 0110111, beq 1100011, I-ALU 0010011, jal 1101111, jalr 1100111.
REQ-019 Field placement: rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-020 R-type: bits [31:25] = {0, funct7b5, 00000}.
REQ-021 I-type (lw, I-ALU, jalr): bits [31:20] = imm[11:0].
REQ-022 I-ALU with funct3 001 or 101 (shifts): bits [31:25] = {0, funct7b5, 00000} and bits [24:20] = imm[4:0].
REQ-023 jalr: funct3 forced to 000.
REQ-024 S, B, U and J immediates use the standard RV32I bit scatter; beq forces funct3 to 000.
REQ-025 Fields unused by a kind are zero in the encoded word.
REQ-026 Encoding is combinational; the encoded word is pushed into the FIFO on the accepting edge (request-to-imem_we latency of 1 cycle when the FIFO is empty).
REQ-027 beq or jal with req_imm[0]=1: the request is accepted, nothing is pushed, and err is set and held until reset or the next start.
REQ-028 imem_we = FIFO not empty; imem_wd = FIFO head; imem_addr is an address counter.
REQ-029 On each completed write: FIFO pops, address counter += 4, count += 1. The counter wraps modulo 2^XLEN.
REQ-030 imem_we, imem_addr and imem_wd hold stable while imem_we && !imem_ready.
REQ-031 If a push and a pop occur in the same cycle on a full FIFO, both proceed and occupancy is unchanged.
REQ-032 busy = (state != IDLE).
REQ-033 done pulses for one cycle on the DRAIN->IDLE transition.
REQ-034 start while in RUN or DRAIN is ignored.
REQ-035 If finish and a request arrive in the same cycle, finish wins and the request is not accepted.

Reset
REQ-036 reset low, at any time including mid-drain: state=IDLE, FIFO empty, imem_we=0, imem_addr=0, count=0, err=0, done=0, req_ready=0; in-flight words are discarded.
REQ-037 start clears count and err and loads base_addr into the address counter.

Structure
REQ-038 A shared package holds the req_kind enumeration, the opcode constants, the state enumeration and an XLEN constant; the control decoder reuses the same opcode constants.
REQ-039 The FIFO is a sub-module, instr_fifo, parameterised by DEPTH and XLEN.

Verification
REQ-040 base 0x100, start; addi x1,x0,5 -> imem_wd 0x00500093 at imem_addr 0x100.
REQ-041 lw x2,8(x1) then sw x2,4(x1) -> 0x0080A103 at 0x104, then 0x0020A223 at 0x108.
REQ-042 beq x1,x2,-4; jal x1,8; lui x5,0x12345 -> 0xFE208EE3, 0x008000EF, 0x123452B7.
REQ-043 imem_ready=0 for 10 cycles with 6 requests offered -> req_ready drops after 4 accepts, outputs stay stable, all 6 words are written in order once ready returns.
REQ-044 jal with imm=3 -> no write, err=1; finish -> done pulse, count unchanged.
REQ-045 reset asserted mid-DRAIN with 3 words queued -> imem_we=0 immediately, count=0, state IDLE.
